// File: rtl/bubble_sort_pkg.sv
// Shared types and sizing for the four-entry bubble-sort register bank.
package bubble_sort_pkg;
  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned NUM_ENTRIES   = 4;
  localparam int unsigned LAST_PASS     = 2;
  localparam int unsigned IDX_W         = 2;
  localparam int unsigned CNT_W         = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_e;
endpackage

// File: rtl/cmp_swap.sv
// Unsigned compare-and-swap: orders a pair and flags when they were out of order.
module cmp_swap #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);
  // Strict compare so equal values stay in place.
  assign swap = a > b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

// File: rtl/bubble_sort4.sv
// Four-entry register bank feeding the MUX41 operands, with an in-place
// bubble-sort sequencer doing one compare-and-swap per clock.
module bubble_sort4
  import bubble_sort_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic             start,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] swap_cnt
);

  logic [WIDTH-1:0] r_q [NUM_ENTRIES];
  logic [WIDTH-1:0] r_d [NUM_ENTRIES];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] pass_q, pass_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic             swapped_q, swapped_d;
  logic [CNT_W-1:0] swap_cnt_q, swap_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] j_hi_c;
  logic [IDX_W-1:0] j_last_c;
  logic [WIDTH-1:0] cmp_a_c, cmp_b_c, cmp_lo_c, cmp_hi_c;
  logic             swap_c;
  logic             pass_end_c;
  logic             sort_end_c;
  logic             start_ok_c;

  // Single comparator shared by every (j, j+1) pair.
  assign j_hi_c  = IDX_W'(j_q + 1'b1);
  assign cmp_a_c = r_q[j_q];
  assign cmp_b_c = r_q[j_hi_c];

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .a    (cmp_a_c),
    .b    (cmp_b_c),
    .lo   (cmp_lo_c),
    .hi   (cmp_hi_c),
    .swap (swap_c)
  );

  // Passes shrink by one because the largest remaining entry has bubbled up.
  assign j_last_c   = IDX_W'(LAST_PASS) - pass_q;
  assign pass_end_c = (state_q == SORT) && (j_q == j_last_c);
  assign sort_end_c = pass_end_c &&
                      (!(swapped_q || swap_c) || (pass_q == IDX_W'(LAST_PASS)));
  assign start_ok_c = (state_q == IDLE) && start && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_ENTRIES); k++) r_q[k] <= '0;
      state_q    <= IDLE;
      pass_q     <= '0;
      j_q        <= '0;
      swapped_q  <= 1'b0;
      swap_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      r_q        <= r_d;
      state_q    <= state_d;
      pass_q     <= pass_d;
      j_q        <= j_d;
      swapped_q  <= swapped_d;
      swap_cnt_q <= swap_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Sequencer: pass/index walk and termination.
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    j_d       = j_q;
    swapped_d = swapped_q;
    case (state_q)
      IDLE: begin
        if (start_ok_c) begin
          state_d   = SORT;
          pass_d    = '0;
          j_d       = '0;
          swapped_d = 1'b0;
        end
      end
      SORT: begin
        if (sort_end_c) begin
          state_d = IDLE;
        end else if (pass_end_c) begin
          pass_d    = IDX_W'(pass_q + 1'b1);
          j_d       = '0;
          swapped_d = 1'b0;
        end else begin
          j_d       = IDX_W'(j_q + 1'b1);
          swapped_d = swapped_q | swap_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status: register writes, swap count, busy/done.
  always_comb begin
    r_d        = r_q;
    swap_cnt_d = swap_cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          r_d[0] = din0;
          r_d[1] = din1;
          r_d[2] = din2;
          r_d[3] = din3;
        end else if (start) begin
          swap_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      SORT: begin
        busy_d = !sort_end_c;
        done_d = sort_end_c;
        if (swap_c) begin
          r_d[j_q]    = cmp_lo_c;
          r_d[j_hi_c] = cmp_hi_c;
          swap_cnt_d  = CNT_W'(swap_cnt_q + 1'b1);
        end
      end
      default: ;
    endcase
  end

  assign r0       = r_q[0];
  assign r1       = r_q[1];
  assign r2       = r_q[2];
  assign r3       = r_q[3];
  assign busy     = busy_q;
  assign done     = done_q;
  assign swap_cnt = swap_cnt_q;

endmodule
